// File: rtl/lsu_pkg.sv
// Shared load/store definitions: access size encodings and alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    // Returns 1 when an access cannot be issued: illegal size, or an address
    // not aligned to the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (lsu_size_e'(size))
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane selection and sign/zero extension from a 32-bit RAM word.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] ext_data
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend per size.
    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        ext_data = '0;
        case (lsu_size_e'(size))
            SZ_BYTE: ext_data = zero_ext ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: ext_data = zero_ext ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            SZ_WORD: ext_data = shifted;
            default: ext_data = '0;
        endcase
    end

endmodule

// File: rtl/ram_lsu_bridge.sv
// Load/store bridge between the CPU request channel and a single-port word RAM.
module ram_lsu_bridge
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_we,
    output logic [3:0]        ram_wstrb,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_e;

    state_e      state, state_next;
    logic        accept;
    logic        req_err;
    logic        do_store;
    logic [3:0]  strb;
    logic [31:0] load_data;

    assign req_ready = (state == ST_IDLE) | rsp_ready;
    assign accept    = req_valid & req_ready;
    assign req_err   = misaligned(req_size, req_addr[1:0]);
    assign do_store  = accept & req_we & ~req_err;
    assign rsp_valid = (state == ST_RESP);

    lsu_load_align u_load_align (
        .rdata    (ram_rdata),
        .addr_lo  (req_addr[1:0]),
        .size     (req_size),
        .zero_ext (req_unsigned),
        .ext_data (load_data)
    );

    // Byte strobes and lane-replicated write data for the requested size.
    always_comb begin
        strb      = '0;
        ram_wdata = req_wdata;
        case (lsu_size_e'(req_size))
            SZ_BYTE: begin
                strb      = 4'b0001 << req_addr[1:0];
                ram_wdata = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                strb      = 4'b0011 << req_addr[1:0];
                ram_wdata = {2{req_wdata[15:0]}};
            end
            SZ_WORD: strb = 4'b1111;
            default: strb = '0;
        endcase
    end

    // RAM-side controls: writes only issue for an accepted, legal store.
    always_comb begin
        ram_we    = do_store;
        ram_wstrb = do_store ? strb : '0;
        ram_addr  = req_valid ? {req_addr[ADDR_W-1:2], 2'b00} : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: load on accept, drain to IDLE when the consumer takes it.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = ST_RESP;
        end else if ((state == ST_RESP) && rsp_ready) begin
            state_next = ST_IDLE;
        end
    end

    // Response register: captured on accept, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_err   <= req_err;
            rsp_rdata <= (req_err || req_we) ? '0 : load_data;
        end
    end

endmodule

// File: tb/tb_ram_lsu_bridge.sv
// Directed self-checking bench for ram_lsu_bridge with a small behavioural RAM.
module tb_ram_lsu_bridge;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_we;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:63];

    ram_lsu_bridge #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_we       (ram_we),
        .ram_wstrb    (ram_wstrb),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 256 bytes, combinational read, byte-strobed write; out of range reads 0.
    assign ram_rdata = (ram_addr < 32'd256) ? mem[ram_addr[7:2]] : 32'd0;

    always @(posedge clk) begin
        if (ram_we && ram_addr < 32'd256) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wstrb[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic clr_req();
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        clr_req();
        #2;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_ram_we",    {31'd0, ram_we}, 32'd0);
        chk("rst_ram_wstrb", {28'd0, ram_wstrb}, 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Word store 0xDEADBEEF @0x10
        set_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        #1;
        chk("st_w_we",    {31'd0, ram_we}, 32'd1);
        chk("st_w_strb",  {28'd0, ram_wstrb}, 32'hF);
        chk("st_w_addr",  ram_addr, 32'h10);
        chk("st_w_wdata", ram_wdata, 32'hDEADBEEF);
        tick();
        clr_req();
        chk("st_w_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("st_w_rsp_err",   {31'd0, rsp_err}, 32'd0);
        chk("st_w_rsp_rdata", rsp_rdata, 32'd0);

        // Byte load unsigned @0x11 -> 0xBE
        set_req(1'b0, 2'b00, 1'b1, 32'h11, 32'hFFFFFFFF);
        #1;
        chk("ld_b_we",   {31'd0, ram_we}, 32'd0);
        chk("ld_b_strb", {28'd0, ram_wstrb}, 32'd0);
        chk("ld_b_addr", ram_addr, 32'h10);
        tick();
        clr_req();
        chk("ld_bu_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ld_bu_rdata", rsp_rdata, 32'h000000BE);
        chk("ld_bu_err",   {31'd0, rsp_err}, 32'd0);

        // Word store 0x00AA5500 @0x20, then byte store 0x80 @0x23
        set_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h00AA5500);
        tick();
        set_req(1'b1, 2'b00, 1'b0, 32'h23, 32'h12345680);
        #1;
        chk("st_b_strb",  {28'd0, ram_wstrb}, 32'h8);
        chk("st_b_wdata", ram_wdata, 32'h80808080);
        chk("st_b_addr",  ram_addr, 32'h20);
        tick();
        set_req(1'b0, 2'b00, 1'b0, 32'h23, 32'd0);
        tick();
        chk("ld_bs_rdata", rsp_rdata, 32'hFFFFFF80);
        set_req(1'b0, 2'b01, 1'b1, 32'h22, 32'd0);
        tick();
        chk("ld_hu_rdata", rsp_rdata, 32'h000080AA);
        set_req(1'b0, 2'b01, 1'b0, 32'h22, 32'd0);
        tick();
        chk("ld_hs_rdata", rsp_rdata, 32'hFFFF80AA);
        set_req(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        tick();
        chk("ld_w20_rdata", rsp_rdata, 32'h80AA5500);

        // Half store 0xBEEF @0x32 then word load @0x30
        set_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h7777BEEF);
        #1;
        chk("st_h_strb",  {28'd0, ram_wstrb}, 32'hC);
        chk("st_h_wdata", ram_wdata, 32'hBEEFBEEF);
        tick();
        set_req(1'b0, 2'b10, 1'b0, 32'h30, 32'd0);
        tick();
        chk("ld_w30_rdata", rsp_rdata, 32'hBEEF0000);

        // Misaligned half load @0x05
        set_req(1'b0, 2'b01, 1'b0, 32'h05, 32'd0);
        #1;
        chk("mis_h_we", {31'd0, ram_we}, 32'd0);
        tick();
        chk("mis_h_err",   {31'd0, rsp_err}, 32'd1);
        chk("mis_h_rdata", rsp_rdata, 32'd0);
        chk("mis_h_valid", {31'd0, rsp_valid}, 32'd1);

        // Misaligned word store @0x06
        set_req(1'b1, 2'b10, 1'b0, 32'h06, 32'hCAFEF00D);
        #1;
        chk("mis_w_we",   {31'd0, ram_we}, 32'd0);
        chk("mis_w_strb", {28'd0, ram_wstrb}, 32'd0);
        tick();
        chk("mis_w_err",   {31'd0, rsp_err}, 32'd1);
        chk("mis_w_rdata", rsp_rdata, 32'd0);
        set_req(1'b0, 2'b10, 1'b0, 32'h04, 32'd0);
        tick();
        chk("mis_w_mem", rsp_rdata, 32'd0);
        chk("mis_w_clr_err", {31'd0, rsp_err}, 32'd0);

        // Illegal size store @0x10
        set_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h11111111);
        #1;
        chk("ill_we", {31'd0, ram_we}, 32'd0);
        tick();
        chk("ill_err",   {31'd0, rsp_err}, 32'd1);
        chk("ill_rdata", rsp_rdata, 32'd0);
        set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        tick();
        chk("ill_mem", rsp_rdata, 32'hDEADBEEF);
        clr_req();
        tick();
        chk("drain_valid", {31'd0, rsp_valid}, 32'd0);

        // Four back-to-back loads, second response stalled for 3 cycles
        set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        tick();
        chk("b2b_r0", rsp_rdata, 32'hDEADBEEF);
        set_req(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        tick();
        chk("b2b_r1", rsp_rdata, 32'h80AA5500);
        rsp_ready = 1'b0;
        set_req(1'b0, 2'b10, 1'b0, 32'h30, 32'd0);
        #1;
        chk("b2b_stall_ready", {31'd0, req_ready}, 32'd0);
        chk("b2b_stall_we",    {31'd0, ram_we}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("b2b_stall_rdata", rsp_rdata, 32'h80AA5500);
            chk("b2b_stall_err",   {31'd0, rsp_err}, 32'd0);
            chk("b2b_stall_rdy",   {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("b2b_release_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk("b2b_r2", rsp_rdata, 32'hBEEF0000);
        set_req(1'b0, 2'b00, 1'b0, 32'h11, 32'd0);
        tick();
        chk("b2b_r3", rsp_rdata, 32'hFFFFFFBE);
        chk("b2b_r3_valid", {31'd0, rsp_valid}, 32'd1);
        clr_req();
        tick();
        chk("b2b_drained", {31'd0, rsp_valid}, 32'd0);

        // Reset asserted with a response held and stalled
        rsp_ready = 1'b0;
        set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        tick();
        clr_req();
        chk("rst_mid_before", {31'd0, rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_rdata", rsp_rdata, 32'd0);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        #3 rst_n = 1'b1;
        tick();
        rsp_ready = 1'b1;
        set_req(1'b0, 2'b00, 1'b1, 32'h32, 32'd0);
        tick();
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
        chk("post_rst_rdata", rsp_rdata, 32'h000000EF);

        // Out-of-range load returns RAM's 0 as normal data
        set_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'd0);
        #1;
        chk("oor_addr", ram_addr, 32'h1000);
        tick();
        chk("oor_rdata", rsp_rdata, 32'd0);
        chk("oor_err",   {31'd0, rsp_err}, 32'd0);
        clr_req();
        #1;
        chk("idle_addr", ram_addr, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
